// File: rtl/cdb_slot_scheduler_pkg.sv
// Shared types and helpers for the CDB slot scheduler: reservation slot layout
// and the field widths every scheduler file agrees on.
package cdb_slot_scheduler_pkg;

  localparam int MAX_FU  = 16;
  localparam int FU_ID_W = 4;
  localparam int LAT_W   = 4;

  typedef struct packed {
    logic               valid;
    logic [FU_ID_W-1:0] fu_id;
  } rsv_slot_t;

  function automatic logic [MAX_FU-1:0] onehot_from_id(input logic [FU_ID_W-1:0] id);
    return MAX_FU'(1) << id;
  endfunction

endpackage

// File: rtl/cdb_slot_scheduler_rr_priority_picker.sv
// Combinational rotating-priority picker: walks FUs from ptr and grants every
// requester whose CDB slot is free, at most one per latency value.
module rr_priority_picker
  import cdb_slot_scheduler_pkg::*;
#(
  parameter int NUM_FU = 4,
  parameter int PTR_W  = 2
) (
  input  logic [NUM_FU-1:0]            req,
  input  logic [PTR_W-1:0]             ptr,
  input  logic [NUM_FU-1:0][LAT_W-1:0] fu_lat,
  input  logic [NUM_FU-1:0]            slot_free,
  output logic [NUM_FU-1:0]            grant,
  output logic [PTR_W-1:0]             next_ptr
);

  logic [(1<<LAT_W)-1:0] lat_taken;
  logic [PTR_W-1:0]      idx;

  // The last grant in evaluation order leaves next_ptr one past itself.
  always_comb begin
    grant     = '0;
    next_ptr  = ptr;
    lat_taken = '0;
    idx       = '0;
    for (int k = 0; k < NUM_FU; k++) begin
      idx = PTR_W'((int'(ptr) + k) % NUM_FU);
      if (req[idx] && slot_free[idx] && !lat_taken[fu_lat[idx]]) begin
        grant[idx]             = 1'b1;
        lat_taken[fu_lat[idx]] = 1'b1;
        next_ptr               = PTR_W'((int'(idx) + 1) % NUM_FU);
      end
    end
  end

endmodule

// File: rtl/cdb_slot_scheduler.sv
// Issue scheduler for NUM_FU functional units sharing one CDB: books the CDB
// cycle of every granted op in a reservation shift register.
module cdb_slot_scheduler
  import cdb_slot_scheduler_pkg::*;
#(
  parameter int                            NUM_FU  = 4,
  parameter int                            MAX_LAT = 8,
  parameter logic [NUM_FU-1:0][LAT_W-1:0]  FU_LAT  = {4'd6, 4'd3, 4'd1, 4'd1},
  parameter logic [NUM_FU-1:0]             FU_PIPE = 4'b0111,
  parameter int                            CNT_W   = 16
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic [NUM_FU-1:0]         i_ready,
  input  logic                      i_flush,
  output logic [NUM_FU-1:0]         o_grant,
  output logic [NUM_FU-1:0]         o_cdb_sel,
  output logic                      o_cdb_valid,
  output logic [$clog2(NUM_FU)-1:0] o_cdb_owner,
  output logic [NUM_FU-1:0]         o_busy,
  output logic [CNT_W-1:0]          o_deny_cnt
);

  localparam int PTR_W = $clog2(NUM_FU);

  rsv_slot_t         rsv [MAX_LAT];
  logic [LAT_W-1:0]  busy_cnt [NUM_FU];
  logic [PTR_W-1:0]  ptr;
  logic [PTR_W-1:0]  next_ptr;
  logic [NUM_FU-1:0] req;
  logic [NUM_FU-1:0] slot_free;
  logic [NUM_FU-1:0] grant;

  // A grant of latency L lands in rsv[L-1] after the shift, so rsv[L] must be free now.
  for (genvar i = 0; i < NUM_FU; i++) begin : g_fu
    localparam int L = int'(FU_LAT[i]);
    if (L >= MAX_LAT) begin : g_top_slot
      assign slot_free[i] = 1'b1;
    end else begin : g_mid_slot
      assign slot_free[i] = !rsv[L].valid;
    end
    assign o_busy[i]    = !FU_PIPE[i] && (busy_cnt[i] != '0);
    assign o_cdb_sel[i] = rsv[0].valid && (rsv[0].fu_id == FU_ID_W'(i));
  end

  assign req = i_ready & ~o_busy & {NUM_FU{~(i_flush | i_rst)}};

  rr_priority_picker #(
    .NUM_FU (NUM_FU),
    .PTR_W  (PTR_W)
  ) u_picker (
    .req       (req),
    .ptr       (ptr),
    .fu_lat    (FU_LAT),
    .slot_free (slot_free),
    .grant     (grant),
    .next_ptr  (next_ptr)
  );

  assign o_grant     = grant;
  assign o_cdb_valid = |o_cdb_sel;
  assign o_cdb_owner = rsv[0].valid ? rsv[0].fu_id[PTR_W-1:0] : '0;

  always_ff @(posedge i_clk) begin
    if (i_rst || i_flush) begin
      for (int k = 0; k < MAX_LAT; k++) rsv[k] <= '0;
    end else begin
      for (int k = 0; k < MAX_LAT-1; k++) rsv[k] <= rsv[k+1];
      rsv[MAX_LAT-1] <= '0;
      for (int i = 0; i < NUM_FU; i++) begin
        if (grant[i]) rsv[int'(FU_LAT[i])-1] <= rsv_slot_t'{valid: 1'b1, fu_id: FU_ID_W'(i)};
      end
    end
  end

  // Counter reaches zero in the cycle the result is on the CDB, so reissue is allowed then.
  always_ff @(posedge i_clk) begin
    for (int i = 0; i < NUM_FU; i++) begin
      if (i_rst || i_flush)              busy_cnt[i] <= '0;
      else if (grant[i] && !FU_PIPE[i])  busy_cnt[i] <= FU_LAT[i] - LAT_W'(1);
      else if (busy_cnt[i] != '0)        busy_cnt[i] <= busy_cnt[i] - LAT_W'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      ptr        <= '0;
      o_deny_cnt <= '0;
    end else if (!i_flush) begin
      if (|grant) ptr <= next_ptr;
      if ((|(i_ready & ~grant)) && !(&o_deny_cnt)) o_deny_cnt <= o_deny_cnt + CNT_W'(1);
    end
  end

  a_cdb_onehot: assert property (@(posedge i_clk) disable iff (i_rst) $onehot0(o_cdb_sel));

endmodule

// File: tb/tb_cdb_slot_scheduler.sv
// Directed bench for cdb_slot_scheduler: expected CDB results are queued at
// issue time and retired by an independent monitor when the CDB is driven.
module tb_cdb_slot_scheduler;

  logic       i_clk = 1'b0;
  logic       i_rst;
  logic [3:0] i_ready;
  logic       i_flush;
  logic [3:0] o_grant;
  logic [3:0] o_cdb_sel;
  logic       o_cdb_valid;
  logic [1:0] o_cdb_owner;
  logic [3:0] o_busy;
  logic [3:0] o_deny_cnt;

  localparam int LAT [4] = '{1, 1, 3, 6};

  typedef struct {
    logic [3:0] sel;
    logic [1:0] owner;
    int         due;
  } exp_t;

  exp_t scb[$];
  int   tests_run    = 0;
  int   tests_failed = 0;
  int   cyc          = 0;
  bit   mon_en       = 1'b0;

  cdb_slot_scheduler #(.CNT_W(4)) dut (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_ready     (i_ready),
    .i_flush     (i_flush),
    .o_grant     (o_grant),
    .o_cdb_sel   (o_cdb_sel),
    .o_cdb_valid (o_cdb_valid),
    .o_cdb_owner (o_cdb_owner),
    .o_busy      (o_busy),
    .o_deny_cnt  (o_deny_cnt)
  );

  always #5 i_clk = ~i_clk;

  always @(posedge i_clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Keep the queue sorted by due cycle; a long-latency op may be issued before a short one.
  task automatic scb_push(input int fu, input int due);
    exp_t e;
    int   pos;
    e.sel   = 4'(1 << fu);
    e.owner = 2'(fu);
    e.due   = due;
    pos     = scb.size();
    for (int j = scb.size() - 1; j >= 0; j--) begin
      if (scb[j].due > due) pos = j;
    end
    scb.insert(pos, e);
  endtask

  task automatic scb_drop();
    while (scb.size() > 0 && scb[scb.size()-1].due > cyc) scb.pop_back();
  endtask

  task automatic applyStimulus(input logic [3:0] rdy, input logic fl, input logic rs,
                               input logic [3:0] exp_grant);
    i_ready = rdy;
    i_flush = fl;
    i_rst   = rs;
    if (fl || rs) scb_drop();
    for (int i = 0; i < 4; i++) begin
      if (exp_grant[i] && !fl && !rs) scb_push(i, cyc + LAT[i]);
    end
    @(negedge i_clk);
    checkOutput("grant", 16'(o_grant), 16'(exp_grant));
  endtask

  task automatic end_cycle();
    @(posedge i_clk);
    #1;
  endtask

  task automatic step(input logic [3:0] rdy, input logic fl, input logic rs,
                      input logic [3:0] exp_grant);
    applyStimulus(rdy, fl, rs, exp_grant);
    end_cycle();
  endtask

  always @(negedge i_clk) begin
    if (mon_en) begin
      while (scb.size() > 0 && scb[0].due < cyc) begin
        tests_run++;
        tests_failed++;
        $display("[TB] FAIL cdb_missing: got idle, expected sel %b due cycle %0d (now %0d)",
                 scb[0].sel, scb[0].due, cyc);
        void'(scb.pop_front());
      end
      if (o_cdb_valid === 1'b1) begin
        if (scb.size() > 0 && scb[0].due == cyc) begin
          checkOutput("cdb_sel", 16'(o_cdb_sel), 16'(scb[0].sel));
          checkOutput("cdb_owner", 16'(o_cdb_owner), 16'(scb[0].owner));
          void'(scb.pop_front());
        end else begin
          tests_run++;
          tests_failed++;
          $display("[TB] FAIL cdb_unexpected: got sel %b, expected idle (cycle %0d)", o_cdb_sel, cyc);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    i_rst   = 1'b1;
    i_ready = 4'b1111;
    i_flush = 1'b0;
    end_cycle();

    // Reset held with everything ready: no grants, clean state afterwards.
    step(4'b1111, 1'b0, 1'b1, 4'b0000);
    step(4'b1111, 1'b0, 1'b1, 4'b0000);
    mon_en = 1'b1;
    applyStimulus(4'b0000, 1'b0, 1'b0, 4'b0000);
    checkOutput("rst_cdb_sel", 16'(o_cdb_sel), 16'h0);
    checkOutput("rst_busy", 16'(o_busy), 16'h0);
    checkOutput("rst_deny", 16'(o_deny_cnt), 16'h0);
    end_cycle();

    // Mult alone: on the CDB three cycles after its grant.
    step(4'b0100, 1'b0, 1'b0, 4'b0100);
    repeat (4) step(4'b0000, 1'b0, 1'b0, 4'b0000);

    // Slot collision: int blocked while mult holds rsv[1].
    step(4'b0000, 1'b0, 1'b1, 4'b0000);
    step(4'b0100, 1'b0, 1'b0, 4'b0100);
    step(4'b0000, 1'b0, 1'b0, 4'b0000);
    step(4'b0001, 1'b0, 1'b0, 4'b0000);
    applyStimulus(4'b0001, 1'b0, 1'b0, 4'b0001);
    checkOutput("collide_deny", 16'(o_deny_cnt), 16'd1);
    end_cycle();
    repeat (2) step(4'b0000, 1'b0, 1'b0, 4'b0000);

    // Rotating priority between the two latency-1 units.
    step(4'b0000, 1'b0, 1'b1, 4'b0000);
    for (int k = 0; k < 6; k++) step(4'b0011, 1'b0, 1'b0, (k % 2 == 0) ? 4'b0001 : 4'b0010);
    applyStimulus(4'b0000, 1'b0, 1'b0, 4'b0000);
    checkOutput("rotate_deny", 16'(o_deny_cnt), 16'd6);
    end_cycle();
    step(4'b0000, 1'b0, 1'b0, 4'b0000);

    // Non-pipelined divider: busy for five cycles, reissued as its result lands.
    step(4'b0000, 1'b0, 1'b1, 4'b0000);
    step(4'b1000, 1'b0, 1'b0, 4'b1000);
    for (int k = 1; k <= 5; k++) begin
      applyStimulus(4'b1000, 1'b0, 1'b0, 4'b0000);
      checkOutput("div_busy", 16'(o_busy), 16'b1000);
      end_cycle();
    end
    applyStimulus(4'b1000, 1'b0, 1'b0, 4'b1000);
    checkOutput("div_free", 16'(o_busy), 16'h0);
    end_cycle();
    applyStimulus(4'b0000, 1'b0, 1'b0, 4'b0000);
    checkOutput("div_busy_again", 16'(o_busy), 16'b1000);
    checkOutput("div_deny", 16'(o_deny_cnt), 16'd5);
    end_cycle();
    repeat (6) step(4'b0000, 1'b0, 1'b0, 4'b0000);

    // Flush squashes the booked mult result; deny count and pointer hold.
    step(4'b0000, 1'b0, 1'b1, 4'b0000);
    step(4'b0100, 1'b0, 1'b0, 4'b0100);
    step(4'b0100, 1'b1, 1'b0, 4'b0000);
    applyStimulus(4'b0100, 1'b0, 1'b0, 4'b0100);
    checkOutput("flush_deny", 16'(o_deny_cnt), 16'h0);
    end_cycle();
    applyStimulus(4'b0000, 1'b0, 1'b0, 4'b0000);
    checkOutput("flush_cdb_idle", 16'(o_cdb_sel), 16'h0);
    end_cycle();
    repeat (3) step(4'b0000, 1'b0, 1'b0, 4'b0000);

    // Reset mid-flight drops the outstanding mult reservation.
    step(4'b0100, 1'b0, 1'b0, 4'b0100);
    step(4'b0000, 1'b0, 1'b1, 4'b0000);
    step(4'b0000, 1'b0, 1'b0, 4'b0000);
    applyStimulus(4'b0000, 1'b0, 1'b0, 4'b0000);
    checkOutput("midrst_cdb_idle", 16'(o_cdb_sel), 16'h0);
    end_cycle();
    repeat (2) step(4'b0000, 1'b0, 1'b0, 4'b0000);

    // Deny counter saturates at all-ones instead of wrapping.
    for (int k = 0; k < 18; k++) begin
      applyStimulus(4'b0011, 1'b0, 1'b0, (k % 2 == 0) ? 4'b0001 : 4'b0010);
      if (k == 15 || k == 17) checkOutput("deny_sat", 16'(o_deny_cnt), 16'd15);
      end_cycle();
    end
    repeat (2) step(4'b0000, 1'b0, 1'b0, 4'b0000);

    checkOutput("scb_drained", 16'(scb.size()), 16'h0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
